tbec_rsc_decoder_fsm: RTL and testbench
=======================================

Name: tbec_rsc_decoder_fsm

Overview:
Downstream consumer of the 32-bit TBEC RSC codeword produced by the 16-bit encoder stage, including words carrying injected errors.
- Recomputes Di/P/Cb check bits and forms syndromes.
- Corrects any single data-bit error, classifies the word and returns the 16-bit data word in encoder input order.
- Uses a valid/ready handshake with a 3-stage FSM (capture, syndrome, correct) and a held output register.

Parameters:
CNT_W, 16, width of the saturating error-statistics counters

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  codeword_in valid
in_ready  output  1  decoder can accept a codeword
codeword_in  input  [0:31]  received codeword, encoder layout
out_valid  output  1  data_out/status valid
out_ready  input  1  downstream accepts result
data_out  output  [0:15]  corrected data, same bit order as encoder data_in
status  output  2  00 clean, 01 data bit corrected, 10 check-bit-only error, 11 uncorrectable
err_pos  output  5  codeword position of the flipped bit (0..31); 0 when status is 00 or 11
cnt_corrected  output  CNT_W  count of words with status 01 or 10
cnt_uncorrectable  output  CNT_W  count of words with status 11

Behaviour:
- Clock and reset:
  - Clock is clk.
  - Reset is rst_n, asynchronous and active-low.
  - Reset drives FSM to IDLE; data_out, status, err_pos and both counters go to 0; out_valid goes to 0.
  - in_ready = 1 only in IDLE, decoded from state.
- Codeword layout:
  - Position 4j+b (b,j in 0..3) carries data bit d[4b+j].
  - Positions 16..19 = Di0, Di3, Di1, Di2.
  - Positions 20..23 = P0, P3, P1, P2.
  - Positions 24..31 = Cb0[0], Cb0[1], Cb1[0], Cb1[1], Cb2[0], Cb2[1], Cb3[0], Cb3[1].
  - Let s[b][j] = d[4b+j].
- Check equations:
  - Cb[b][k] = s[b][k]^s[b][k+2].
  - P0 = s00^s01^s10^s11; P1 = s20^s21^s30^s31; P2 = s02^s03^s12^s13; P3 = s22^s23^s32^s33.
  - Di0 = s00^s11^s20^s31; Di1 = s01^s10^s21^s30; Di2 = s02^s13^s22^s33; Di3 = s03^s12^s23^s32.
- FSM states: IDLE -> SYND -> CORR -> OUT -> IDLE.
  - IDLE: on in_valid && in_ready, register codeword_in; go to SYND.
  - SYND: register syndromes SC[8], SP[4], SD[4] = received check bits XOR recomputed check bits.
  - CORR: classify using the syndrome weights wC, wP, wD:
    - All zero -> status 00.
    - wC=wP=wD=1 and all three point to the same s[b][j] -> flip that bit; status 01; err_pos = 4j+b.
      - Cb[b][j mod 2] selects b and j parity; P selects j half; Di must agree.
    - Exactly one syndrome bit set in total -> status 10; data unchanged; err_pos = that check position.
    - Anything else (including an inconsistent triple) -> status 11; data passed uncorrected.
  - OUT: out_valid = 1; outputs held stable while out_ready = 0. On out_ready, go to IDLE with out_valid = 0 the next cycle.
- Timing:
  - Latency: out_valid asserts 3 cycles after the accepting edge.
  - Throughput: one word per 4 cycles minimum.
  - in_valid while busy is ignored (in_ready = 0); upstream holds the word.
- Counters:
  - Update on the CORR -> OUT transition.
  - Saturate at all-ones and do not wrap.
  - A status 01 or 10 word increments cnt_corrected; a status 11 word increments cnt_uncorrectable.
- Reset mid-operation: the in-flight word is discarded, out_valid drops immediately, and no counter update occurs.

Optional Feature:
Macro TBEC_DEC_STATS_EN.
- Defined: cnt_corrected and cnt_uncorrectable are implemented as above.
- Undefined: no counter registers are built; both counter outputs are tied to 0.
- All other behaviour is identical either way.

Test Plan:
- Clean words:
  - codeword 32'h00000000 -> data_out 16'h0000, status 00, out_valid 3 cycles after accept.
  - codeword 32'hFFFF0000 (data 16'hFFFF) -> data_out 16'hFFFF, status 00.
- Single data-bit error: data 0, flip position 1 (codeword 32'h40000000) -> data_out 16'h0800 corrected to 16'h0000, status 01, err_pos 1, cnt_corrected = 1.
  - Hold the 32'h40000000 stimulus but expect data_out 16'h0000 (d[4] restored).
- Check-bit-only error: 32'hFFFF0001 (position 31 flipped) -> data_out 16'hFFFF, status 10, err_pos 31.
- Uncorrectable: 32'hC0000000 (positions 0 and 1 flipped) -> status 11, data_out 16'h8800 uncorrected, err_pos 0, cnt_uncorrectable = 1.
- Backpressure and reset:
  - Hold out_ready = 0 for 5 cycles -> outputs stable, in_ready = 0, and a second in_valid word is not accepted until after release.
  - Assert rst_n = 0 during SYND -> out_valid 0, counters unchanged at 0, in_ready = 1 after release.

Source files
------------

// File: rtl/tbec_rsc_decoder_fsm.sv
// tbec_rsc_decoder_fsm: TBEC RSC 32-bit codeword decoder with single data-bit correction and valid/ready handshake.
// Error-statistics counters are built only when TBEC_DEC_STATS_EN is defined; otherwise both counter outputs read 0.
module tbec_rsc_decoder_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:31]      codeword_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:15]      data_out,
  output logic [1:0]       status,
  output logic [4:0]       err_pos,
  output logic [CNT_W-1:0] cnt_corrected,
  output logic [CNT_W-1:0] cnt_uncorrectable
);
  typedef enum logic [1:0] {IDLE, SYND, CORR, OUT} state_t;
  state_t      r_state, w_next;
  logic [0:31] r_cw;
  logic [0:15] r_syn, r_data, w_data, w_flip;
  logic [1:0]  r_status, w_status;
  logic [4:0]  r_pos, w_pos, w_wc, w_wp, w_wd, w_tot;
  logic [7:0]  w_sc;
  logic [3:0]  w_sp, w_sd;
  logic        w_triple;

  // Check bits in codeword order 16..31: Di0 Di3 Di1 Di2 P0 P3 P1 P2 Cb0[0..1] .. Cb3[0..1]
  function automatic logic [0:15] enc(input logic [0:15] d);
    logic [0:15] c;
    c[0] = d[0] ^ d[5] ^ d[8]  ^ d[13];
    c[1] = d[3] ^ d[6] ^ d[11] ^ d[14];
    c[2] = d[1] ^ d[4] ^ d[9]  ^ d[12];
    c[3] = d[2] ^ d[7] ^ d[10] ^ d[15];
    c[4] = d[0] ^ d[1] ^ d[4]  ^ d[5];
    c[5] = d[10] ^ d[11] ^ d[14] ^ d[15];
    c[6] = d[8] ^ d[9] ^ d[12] ^ d[13];
    c[7] = d[2] ^ d[3] ^ d[6]  ^ d[7];
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 2; k++)
        c[8+2*b+k] = d[4*b+k] ^ d[4*b+k+2];
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? SYND : IDLE;
      SYND:    w_next = CORR;
      CORR:    w_next = OUT;
      default: w_next = out_ready ? IDLE : OUT;
    endcase
  end

  always_comb begin
    in_ready  = r_state == IDLE;
    out_valid = r_state == OUT;
  end

  // Syndromes regrouped so that index i of each vector is check bit i of its family
  assign w_sd = {r_syn[1], r_syn[3], r_syn[2], r_syn[0]};
  assign w_sp = {r_syn[5], r_syn[7], r_syn[6], r_syn[4]};
  always_comb begin
    w_sc = '0;
    for (int i = 0; i < 8; i++) w_sc[i] = r_syn[8+i];
  end
  assign w_wc     = 5'($countones(w_sc));
  assign w_wp     = 5'($countones(w_sp));
  assign w_wd     = 5'($countones(w_sd));
  assign w_tot    = w_wc + w_wp + w_wd;
  assign w_triple = w_wc == 5'd1 && w_wp == 5'd1 && w_wd == 5'd1;

  // A data bit s[b][j] sits in Cb[b][j%2], P[b/2 + 2*(j/2)] and Di[2*(j/2) + (b^j)%2]
  always_comb begin
    w_data = '0;
    w_flip = '0;
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 4; j++) begin
        w_data[4*b+j] = r_cw[4*j+b];
        w_flip[4*b+j] = w_triple & w_sc[2*b+j%2] & w_sp[b/2+2*(j/2)] & w_sd[2*(j/2)+((b^j)&1)];
      end
  end

  assign w_status = r_syn == '0 ? 2'b00 : |w_flip ? 2'b01 : w_tot == 5'd1 ? 2'b10 : 2'b11;

  always_comb begin
    w_pos = '0;
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 4; j++)
        if (w_flip[4*b+j]) w_pos = 5'(4*j+b);
    for (int i = 0; i < 16; i++)
      if (w_tot == 5'd1 && r_syn[i]) w_pos = 5'(16+i);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cw     <= '0;
      r_syn    <= '0;
      r_data   <= '0;
      r_status <= '0;
      r_pos    <= '0;
    end else begin
      if (r_state == IDLE && in_valid) r_cw <= codeword_in;
      if (r_state == SYND) r_syn <= r_cw[16:31] ^ enc(w_data);
      if (r_state == CORR) begin
        r_data   <= w_data ^ w_flip;
        r_status <= w_status;
        r_pos    <= w_pos;
      end
    end

  assign data_out = r_data;
  assign status   = r_status;
  assign err_pos  = r_pos;

`ifdef TBEC_DEC_STATS_EN
  logic [CNT_W-1:0] r_cnt_c, r_cnt_u;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt_c <= '0;
      r_cnt_u <= '0;
    end else if (r_state == CORR) begin
      if ((w_status == 2'b01 || w_status == 2'b10) && r_cnt_c != '1) r_cnt_c <= r_cnt_c + 1'b1;
      if (w_status == 2'b11 && r_cnt_u != '1) r_cnt_u <= r_cnt_u + 1'b1;
    end
  assign cnt_corrected     = r_cnt_c;
  assign cnt_uncorrectable = r_cnt_u;
`else
  assign cnt_corrected     = '0;
  assign cnt_uncorrectable = '0;
`endif
endmodule

// File: tb/tb_tbec_rsc_decoder_fsm.sv
// tb_tbec_rsc_decoder_fsm: directed and random stimulus against a nearest-codeword reference decoder.
module tb_tbec_rsc_decoder_fsm;
`ifdef TBEC_DEC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [0:31] codeword_in = '0;
  logic        in_ready, out_valid;
  logic [0:15] data_out;
  logic [1:0]  status;
  logic [4:0]  err_pos;
  logic [15:0] cnt_corrected, cnt_uncorrectable;
  int n_run = 0, n_fail = 0;
  int m_ph = 0, m_cc = 0, m_cu = 0;
  bit m_took = 1'b0;
  logic [0:15] m_d = '0, t_d;
  logic [1:0]  m_st = '0, t_st;
  logic [4:0]  m_pos = '0, t_pos;

  always #5 clk = ~clk;

  tbec_rsc_decoder_fsm #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .codeword_in(codeword_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .status(status), .err_pos(err_pos),
    .cnt_corrected(cnt_corrected), .cnt_uncorrectable(cnt_uncorrectable)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [0:15] b_extract(input logic [0:31] cw);
    logic [0:15] d;
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 4; j++) d[4*b+j] = cw[4*j+b];
    return d;
  endfunction

  function automatic logic [0:31] b_encode(input logic [0:15] d);
    logic s[4][4];
    logic [0:31] cw;
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 4; j++) begin
        s[b][j] = d[4*b+j];
        cw[4*j+b] = s[b][j];
      end
    cw[16] = s[0][0] ^ s[1][1] ^ s[2][0] ^ s[3][1];
    cw[17] = s[0][3] ^ s[1][2] ^ s[2][3] ^ s[3][2];
    cw[18] = s[0][1] ^ s[1][0] ^ s[2][1] ^ s[3][0];
    cw[19] = s[0][2] ^ s[1][3] ^ s[2][2] ^ s[3][3];
    cw[20] = s[0][0] ^ s[0][1] ^ s[1][0] ^ s[1][1];
    cw[21] = s[2][2] ^ s[2][3] ^ s[3][2] ^ s[3][3];
    cw[22] = s[2][0] ^ s[2][1] ^ s[3][0] ^ s[3][1];
    cw[23] = s[0][2] ^ s[0][3] ^ s[1][2] ^ s[1][3];
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 2; k++) cw[24+2*b+k] = s[b][k] ^ s[b][k+2];
    return cw;
  endfunction

  function automatic bit is_cw(input logic [0:31] cw);
    return b_encode(b_extract(cw)) == cw;
  endfunction

  // Reference decoder: valid word, else search for the single flip that yields a valid word
  function automatic void model_dec(input logic [0:31] cw, output logic [0:15] d,
                                    output logic [1:0] st, output logic [4:0] pos);
    logic [0:31] c2;
    d = b_extract(cw);
    st = 2'd3;
    pos = 5'd0;
    if (is_cw(cw)) st = 2'd0;
    else
      for (int p = 0; p < 32; p++) begin
        c2 = cw;
        c2[p] = ~c2[p];
        if (st == 2'd3 && is_cw(c2)) begin
          d = b_extract(c2);
          st = p < 16 ? 2'd1 : 2'd2;
          pos = 5'(p);
        end
      end
  endfunction

  function automatic logic [0:31] rand_cw();
    logic [0:31] cw;
    int m;
    cw = b_encode(16'($urandom));
    m = $urandom_range(0, 3);
    if (m >= 1 && m <= 2) cw[$urandom_range(0, 31)] ^= 1'b1;
    if (m == 2) cw[$urandom_range(0, 31)] ^= 1'b1;
    if (m == 3) cw = $urandom;
    return cw;
  endfunction

  // Transaction-level model: accept, two processing cycles, then present until taken
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0;
      m_cc = 0;
      m_cu = 0;
    end else if (m_ph == 0) begin
      if (in_valid) begin
        model_dec(codeword_in, m_d, m_st, m_pos);
        m_ph = 1;
        m_took = 1'b1;
      end
    end else if (m_ph == 1) m_ph = 2;
    else if (m_ph == 2) begin
      m_ph = 3;
      if (m_st == 2'd1 || m_st == 2'd2) m_cc = m_cc == 65535 ? m_cc : m_cc + 1;
      if (m_st == 2'd3) m_cu = m_cu == 65535 ? m_cu : m_cu + 1;
    end else if (out_ready) m_ph = 0;
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(m_ph == 0));
    chk("out_valid", 32'(out_valid), 32'(m_ph == 3));
    if (m_ph == 3) begin
      chk("data_out", 32'(data_out), 32'(m_d));
      chk("status", 32'(status), 32'(m_st));
      chk("err_pos", 32'(err_pos), 32'(m_pos));
    end
    chk("cnt_corrected", 32'(cnt_corrected), STATS ? 32'(m_cc) : 32'd0);
    chk("cnt_uncorrectable", 32'(cnt_uncorrectable), STATS ? 32'(m_cu) : 32'd0);
  end

  task automatic start(input logic [0:31] cw);
    @(negedge clk);
    in_valid = 1'b1;
    codeword_in = cw;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [0:15] d, input logic [1:0] st, input logic [4:0] pos);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 10);
    chk({nm, " latency"}, 32'(k), 32'd3);
    chk({nm, " data"}, 32'(data_out), 32'(d));
    chk({nm, " status"}, 32'(status), 32'(st));
    chk({nm, " err_pos"}, 32'(err_pos), 32'(pos));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst data_out", 32'(data_out), 32'd0);
    chk("rst status", 32'(status), 32'd0);
    chk("rst err_pos", 32'(err_pos), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst cnt_c", 32'(cnt_corrected), 32'd0);
    chk("rst cnt_u", 32'(cnt_uncorrectable), 32'd0);
    model_dec(32'h00000000, t_d, t_st, t_pos);
    chk("model zero", {14'd0, t_st, t_d}, {14'd0, 2'd0, 16'h0000});
    model_dec(32'hFFFF0000, t_d, t_st, t_pos);
    chk("model ones", {14'd0, t_st, t_d}, {14'd0, 2'd0, 16'hFFFF});
    model_dec(32'h40000000, t_d, t_st, t_pos);
    chk("model data flip", {9'd0, t_pos, t_st, t_d}, {9'd0, 5'd1, 2'd1, 16'h0000});
    model_dec(32'hFFFF0001, t_d, t_st, t_pos);
    chk("model check flip", {9'd0, t_pos, t_st, t_d}, {9'd0, 5'd31, 2'd2, 16'hFFFF});
    model_dec(32'hC0000000, t_d, t_st, t_pos);
    chk("model double", {9'd0, t_pos, t_st, t_d}, {9'd0, 5'd0, 2'd3, 16'h8800});
    start(32'h40000000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst cnt_c", 32'(cnt_corrected), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("post-rst out_valid", 32'(out_valid), 32'd0);
      chk("post-rst in_ready", 32'(in_ready), 32'd1);
      chk("post-rst cnt_c", 32'(cnt_corrected), 32'd0);
    end
    start(32'h00000000);
    expect_out("zero", 16'h0000, 2'd0, 5'd0);
    release_out();
    start(32'hFFFF0000);
    expect_out("ones", 16'hFFFF, 2'd0, 5'd0);
    release_out();
    start(32'h40000000);
    expect_out("data flip", 16'h0000, 2'd1, 5'd1);
    chk("cnt_c after data flip", 32'(cnt_corrected), STATS ? 32'd1 : 32'd0);
    release_out();
    start(32'hFFFF0001);
    expect_out("check flip", 16'hFFFF, 2'd2, 5'd31);
    chk("cnt_c after check flip", 32'(cnt_corrected), STATS ? 32'd2 : 32'd0);
    release_out();
    start(32'hC0000000);
    expect_out("double", 16'h8800, 2'd3, 5'd0);
    chk("cnt_u after double", 32'(cnt_uncorrectable), STATS ? 32'd1 : 32'd0);
    in_valid = 1'b1;
    codeword_in = 32'hFFFF0000;
    repeat (5) begin
      @(negedge clk);
      chk("hold data", 32'(data_out), 32'h8800);
      chk("hold status", 32'(status), 32'd3);
      chk("hold out_valid", 32'(out_valid), 32'd1);
      chk("hold in_ready", 32'(in_ready), 32'd0);
    end
    release_out();
    chk("released out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    expect_out("second word", 16'hFFFF, 2'd0, 5'd0);
    release_out();
    m_took = 1'b0;
    repeat (1500) begin
      @(negedge clk);
      if (!in_valid || m_took) begin
        m_took = 1'b0;
        in_valid = 1'($urandom_range(0, 1));
        codeword_in = rand_cw();
      end
      out_ready = $urandom_range(0, 3) != 0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
